mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory request/response interface between the instruction-fetch port and the load/store data port.
- Grants at most one requester per cycle. Data has default priority; a starvation counter forces an instruction grant after a bounded wait.
- An in-order owner FIFO tracks accepted requests and routes each response back to the requester that issued it.
- Sits between the core's fetch/LSU interfaces and the shared testbench memory or SRAM wrapper.

Parameters:
- ADDR_WIDTH, 32: address width on all ports.
- MAX_OUTSTANDING, 2: owner-FIFO depth; maximum accepted requests still awaiting a response (>=1).
- MAX_WAIT, 4: cycles instr_req may be refused before it takes priority (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_req  in  1  fetch request; held with instr_addr until instr_gnt.
- instr_addr  in  ADDR_WIDTH  fetch byte address.
- instr_gnt  out  1  fetch request accepted this cycle.
- instr_valid  out  1  fetch response valid.
- instr_rdata  out  32  fetch response data.
- instr_err  out  1  fetch response error; qualified by instr_valid.
- data_req  in  1  data request; held with all data_* fields until data_gnt.
- data_wr  in  1  1 = write, 0 = read.
- data_addr  in  ADDR_WIDTH  data byte address.
- data_wdata  in  32  write data.
- data_byteen  in  4  byte enables.
- data_gnt  out  1  data request accepted this cycle.
- data_valid  out  1  data response valid; returned for both reads and writes.
- data_rdata  out  32  data response data.
- data_err  out  1  data response error; qualified by data_valid.
- mem_req  out  1  request to memory.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_wr  out  1  write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  32  memory write data.
- mem_byteen  out  4  memory byte enables.
- mem_rvalid  in  1  memory response valid; responses are in order.
- mem_rdata  in  32  memory response data.
- mem_err  in  1  memory response error.
- proto_err  out  1  sticky flag: response arrived with no outstanding request.

Behaviour:
- Reset (async, active-high): owner FIFO emptied, outstanding count = 0, starve_cnt = 0, proto_err = 0.
  - All outputs 0 while in reset, including mem_req, *_gnt, *_valid, *_rdata, *_err.
- Selection (combinational):
  - sel_data = data_req & ~(instr_req & starve_cnt == MAX_WAIT).
  - sel_instr = instr_req & ~sel_data.
- Request side:
  - full = (outstanding count == MAX_OUTSTANDING).
  - mem_req = (instr_req | data_req) & ~full.
  - mem_addr/mem_wr/mem_wdata/mem_byteen are muxed from the selected requester.
  - Instr selected: mem_wr = 0, mem_byteen = 4'hf, mem_wdata = 0.
  - No request: all mem_* outputs = 0.
  - instr_gnt = mem_req & mem_gnt & sel_instr; data_gnt = mem_req & mem_gnt & sel_data. Same cycle as mem_gnt, with a combinational path from mem_gnt.
- Owner FIFO:
  - Push on mem_req & mem_gnt, storing the owner bit (0 = instr, 1 = data).
  - Pop on mem_rvalid when non-empty.
  - full is computed from the registered count; a pop in the same cycle does not unblock a push. mem_req reasserts the cycle after the pop.
  - Simultaneous push and pop when not full: count unchanged, order preserved.
  - Pointers wrap modulo MAX_OUTSTANDING; the count register is wide enough for MAX_OUTSTANDING.
- Response routing (combinational from mem_rvalid):
  - Head owner = 0: instr_valid = 1, instr_rdata = mem_rdata, instr_err = mem_err.
  - Head owner = 1: data_valid = 1, data_rdata = mem_rdata, data_err = mem_err.
  - The non-selected rdata is 0. The two valids are never both 1.
- Minimum latency: a grant in cycle N with a 1-cycle memory gives the response valid in cycle N+1.
- mem_rvalid with an empty FIFO: response dropped, no valid raised, proto_err set. proto_err stays 1 until reset.
- Starvation counter:
  - Width $clog2(MAX_WAIT+1).
  - Increments each cycle instr_req & ~instr_gnt, saturating at MAX_WAIT.
  - Cleared on instr_gnt or when instr_req = 0.
  - Stalls caused by full or mem_gnt = 0 also count.
- Reset mid-operation: outstanding entries are discarded. Memory must be reset in the same cycles; any late response sets proto_err.
- Requesters must not drop *_req or change fields before grant. Behaviour if they do is undefined (no recovery logic).

Test Plan:
- Only instr_req, addr 0x100, mem_gnt=1, mem_rvalid next cycle with rdata 0x12345678 -> instr_gnt cycle 0, instr_valid=1 and instr_rdata=0x12345678 in cycle 1, data_valid=0.
- instr_req and data_req (write, byteen 4'b0011) both in cycle 0, starve_cnt=0 -> data_gnt cycle 0 with mem_wr=1, mem_byteen=3; instr_gnt cycle 1; data_valid cycle 1, instr_valid cycle 2.
- data_req held with back-to-back new requests, instr_req held, MAX_WAIT=4, mem_gnt=1 -> data granted cycles 0-3; starve_cnt reaches 4; instr_gnt cycle 4; starve_cnt=0 in cycle 5.
- mem_gnt=1, mem_rvalid withheld, MAX_OUTSTANDING=2 -> two grants, then mem_req=0; one mem_rvalid in cycle k -> mem_req=1 in cycle k+1.
- Instr granted, then data granted; responses return 0xA then 0xB with mem_err=1 on the second -> instr_valid with 0xA and instr_err=0, then data_valid with 0xB and data_err=1.
- mem_rvalid with empty FIFO -> no valid output, proto_err=1 held; assert reset for 1 cycle mid-traffic -> proto_err=0, count=0, mem_req=0 during reset.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and shared-memory handshakes around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the core/memory environment.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  instr_req;
  logic [ADDR_WIDTH-1:0] instr_addr;
  logic                  instr_gnt;
  logic                  instr_valid;
  logic [31:0]           instr_rdata;
  logic                  instr_err;

  logic                  data_req;
  logic                  data_wr;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [31:0]           data_wdata;
  logic [3:0]            data_byteen;
  logic                  data_gnt;
  logic                  data_valid;
  logic [31:0]           data_rdata;
  logic                  data_err;

  logic                  mem_req;
  logic                  mem_gnt;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_byteen;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;
  logic                  mem_err;

  logic                  proto_err;

  modport slave (
    input  instr_req, instr_addr,
    output instr_gnt, instr_valid, instr_rdata, instr_err,
    input  data_req, data_wr, data_addr, data_wdata, data_byteen,
    output data_gnt, data_valid, data_rdata, data_err,
    output mem_req, mem_wr, mem_addr, mem_wdata, mem_byteen,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
    output proto_err
  );

  modport master (
    output instr_req, instr_addr,
    input  instr_gnt, instr_valid, instr_rdata, instr_err,
    output data_req, data_wr, data_addr, data_wdata, data_byteen,
    input  data_gnt, data_valid, data_rdata, data_err,
    input  mem_req, mem_wr, mem_addr, mem_wdata, mem_byteen,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err,
    input  proto_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one in-order memory port between fetch and load/store; data wins by default,
// a starvation counter forces fetch after MAX_WAIT refusals, an owner FIFO routes responses.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned MAX_WAIT        = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned SW    = $clog2(MAX_WAIT + 1);

  logic [MAX_OUTSTANDING-1:0] owner_q;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic [SW-1:0]              starve_cnt;
  logic                       proto_err_q;

  logic starved, sel_data, sel_instr, full, empty, req, push, pop, head;
  logic instr_gnt_int;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Selection and FIFO control; everything is forced quiet while reset is high
  always_comb begin
    starved       = bus.instr_req && (starve_cnt == SW'(MAX_WAIT));
    sel_data      = bus.data_req && !starved;
    sel_instr     = bus.instr_req && !sel_data;
    full          = (count == CNT_W'(MAX_OUTSTANDING));
    empty         = (count == '0);
    req           = (bus.instr_req || bus.data_req) && !full && !reset;
    push          = req && bus.mem_gnt;
    pop           = bus.mem_rvalid && !empty && !reset;
    head          = owner_q[rd_ptr];
    instr_gnt_int = push && sel_instr;
  end

  // Request mux towards memory and grants back to the requesters
  always_comb begin
    bus.mem_req    = req;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_byteen = '0;
    bus.instr_gnt  = instr_gnt_int;
    bus.data_gnt   = push && sel_data;
    if (req) begin
      if (sel_data) begin
        bus.mem_wr     = bus.data_wr;
        bus.mem_addr   = bus.data_addr;
        bus.mem_wdata  = bus.data_wdata;
        bus.mem_byteen = bus.data_byteen;
      end else begin
        bus.mem_addr   = bus.instr_addr;
        bus.mem_byteen = 4'hf;
      end
    end
  end

  // Response routing by the owner at the FIFO head; orphan responses are dropped
  always_comb begin
    bus.instr_valid = 1'b0;
    bus.instr_rdata = '0;
    bus.instr_err   = 1'b0;
    bus.data_valid  = 1'b0;
    bus.data_rdata  = '0;
    bus.data_err    = 1'b0;
    if (pop) begin
      if (head) begin
        bus.data_valid = 1'b1;
        bus.data_rdata = bus.mem_rdata;
        bus.data_err   = bus.mem_err;
      end else begin
        bus.instr_valid = 1'b1;
        bus.instr_rdata = bus.mem_rdata;
        bus.instr_err   = bus.mem_err;
      end
    end
  end

  assign bus.proto_err = proto_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      starve_cnt  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (push) begin
        owner_q[wr_ptr] <= sel_data;
        wr_ptr          <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Every refused cycle counts, whether lost to data, a full FIFO or mem_gnt low
      if (bus.instr_req && !instr_gnt_int) begin
        if (!starved) starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end
      if (bus.mem_rvalid && empty) proto_err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a queue-based reference model.
module tb_mem_port_arbiter;
  localparam int unsigned AW   = 32;
  localparam int unsigned MAXO = 2;
  localparam int unsigned MW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW)) bus();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: owners of accepted requests in issue order, refusal count, sticky error
  bit m_own[$];
  int m_starve = 0;
  bit m_proto  = 0;

  logic          e_mreq, e_mwr, e_igt, e_dgt, e_iv, e_ie, e_dv, e_de, e_proto;
  logic [AW-1:0] e_maddr;
  logic [31:0]   e_mwdata, e_ird, e_drd;
  logic [3:0]    e_mbe;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Predict all outputs for the current inputs and compare them mid-cycle
  task automatic settle();
    bit full, starved, sd, si;
    #1;
    {e_mreq, e_mwr, e_igt, e_dgt, e_iv, e_ie, e_dv, e_de, e_proto} = '0;
    e_maddr = '0; e_mwdata = '0; e_ird = '0; e_drd = '0; e_mbe = '0;
    if (!rst) begin
      full    = (m_own.size() == MAXO);
      starved = bus.instr_req && (m_starve == MW);
      sd      = bus.data_req && !starved;
      si      = bus.instr_req && !sd;
      e_mreq  = (bus.instr_req || bus.data_req) && !full;
      if (e_mreq) begin
        if (sd) begin
          e_mwr = bus.data_wr; e_maddr = bus.data_addr;
          e_mwdata = bus.data_wdata; e_mbe = bus.data_byteen;
        end else begin
          e_maddr = bus.instr_addr; e_mbe = 4'hf;
        end
        e_igt = si && bus.mem_gnt;
        e_dgt = sd && bus.mem_gnt;
      end
      if (bus.mem_rvalid && m_own.size() > 0) begin
        if (m_own[0]) begin e_dv = 1; e_drd = bus.mem_rdata; e_de = bus.mem_err; end
        else          begin e_iv = 1; e_ird = bus.mem_rdata; e_ie = bus.mem_err; end
      end
      e_proto = m_proto;
    end
    chk("mem_req", bus.mem_req, e_mreq);
    chk("mem_wr", bus.mem_wr, e_mwr);
    chk("mem_addr", bus.mem_addr, e_maddr);
    chk("mem_wdata", bus.mem_wdata, e_mwdata);
    chk("mem_byteen", bus.mem_byteen, e_mbe);
    chk("instr_gnt", bus.instr_gnt, e_igt);
    chk("data_gnt", bus.data_gnt, e_dgt);
    chk("instr_valid", bus.instr_valid, e_iv);
    chk("instr_rdata", bus.instr_rdata, e_ird);
    chk("instr_err", bus.instr_err, e_ie);
    chk("data_valid", bus.data_valid, e_dv);
    chk("data_rdata", bus.data_rdata, e_drd);
    chk("data_err", bus.data_err, e_de);
    chk("proto_err", bus.proto_err, e_proto);
  endtask

  // Advance the reference to the next cycle, then step to just after the next rising edge
  task automatic tick();
    if (rst) begin
      m_own.delete(); m_starve = 0; m_proto = 0;
    end else begin
      if (bus.mem_rvalid) begin
        if (m_own.size() > 0) void'(m_own.pop_front());
        else m_proto = 1;
      end
      if (e_igt || e_dgt) m_own.push_back(e_dgt);
      if (bus.instr_req && !e_igt) m_starve = (m_starve < MW) ? m_starve + 1 : MW;
      else m_starve = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.instr_req = 0; bus.data_req = 0;
    for (int g = 0; g < 10 && m_own.size() > 0; g++) begin
      bus.mem_rvalid = 1; bus.mem_rdata = $urandom; bus.mem_err = 0;
      settle(); tick();
    end
    chk("drain_empty", 64'(m_own.size()), 64'd0);
    bus.mem_rvalid = 0;
  endtask

  initial begin
    bus.instr_req = 0; bus.instr_addr = '0;
    bus.data_req = 0; bus.data_wr = 0; bus.data_addr = '0; bus.data_wdata = '0; bus.data_byteen = '0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0; bus.mem_err = 0;

    // Reset state, with requests pending and a stray response
    #1;
    bus.instr_req = 1; bus.data_req = 1; bus.mem_gnt = 1; bus.mem_rvalid = 1;
    settle(); tick();
    settle(); tick();
    rst = 0;
    bus.instr_req = 0; bus.data_req = 0; bus.mem_rvalid = 0;
    settle(); tick();

    // Fetch only, one-cycle memory
    bus.instr_req = 1; bus.instr_addr = 32'h100; bus.mem_gnt = 1;
    settle();
    chk("t1_igrant", bus.instr_gnt, 1'b1);
    chk("t1_addr", bus.mem_addr, 32'h100);
    tick();
    bus.instr_req = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h12345678;
    settle();
    chk("t1_ivalid", bus.instr_valid, 1'b1);
    chk("t1_irdata", bus.instr_rdata, 32'h12345678);
    chk("t1_dvalid", bus.data_valid, 1'b0);
    tick();
    bus.mem_rvalid = 0;

    // Simultaneous requests: data first
    bus.instr_req = 1; bus.instr_addr = 32'h200;
    bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h300;
    bus.data_wdata = 32'hdeadbeef; bus.data_byteen = 4'b0011;
    settle();
    chk("t2_dgrant", bus.data_gnt, 1'b1);
    chk("t2_igrant0", bus.instr_gnt, 1'b0);
    chk("t2_wr", bus.mem_wr, 1'b1);
    chk("t2_byteen", bus.mem_byteen, 4'h3);
    tick();
    bus.data_req = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h55;
    settle();
    chk("t2_igrant1", bus.instr_gnt, 1'b1);
    chk("t2_dvalid", bus.data_valid, 1'b1);
    tick();
    bus.instr_req = 0; bus.mem_rdata = 32'h66;
    settle();
    chk("t2_ivalid", bus.instr_valid, 1'b1);
    tick();
    bus.mem_rvalid = 0; bus.data_wr = 0;

    // Starvation: back-to-back data holds fetch off for exactly MAX_WAIT cycles
    bus.instr_req = 1; bus.instr_addr = 32'h400;
    bus.data_req = 1; bus.data_addr = 32'h500; bus.data_byteen = 4'hf;
    for (int c = 0; c < 7; c++) begin
      bus.mem_rvalid = (m_own.size() > 0); bus.mem_rdata = 32'(c);
      if (c == 5) bus.instr_addr = 32'h404;
      if (c == 6) bus.data_req = 0;
      settle();
      if (c < 4) begin
        chk("t3_dgrant", bus.data_gnt, 1'b1);
        chk("t3_iwait", bus.instr_gnt, 1'b0);
      end else if (c == 4) begin
        chk("t3_iforced", bus.instr_gnt, 1'b1);
        chk("t3_dheld", bus.data_gnt, 1'b0);
      end else if (c == 5) begin
        chk("t3_starve_clr", bus.data_gnt, 1'b1);
      end else begin
        chk("t3_ilast", bus.instr_gnt, 1'b1);
      end
      tick();
      bus.data_addr = bus.data_addr + 32'd4;
    end
    drain();

    // Outstanding limit: the pop cycle does not unblock a push
    bus.data_req = 1; bus.mem_gnt = 1; bus.mem_rvalid = 0;
    for (int c = 0; c < 5; c++) begin
      bus.mem_rvalid = (c == 3);
      settle();
      if (c < 2) chk("t4_grant", bus.data_gnt, 1'b1);
      else if (c < 4) chk("t4_full", bus.mem_req, 1'b0);
      else chk("t4_resume", bus.mem_req, 1'b1);
      tick();
      bus.data_addr = bus.data_addr + 32'd4;
    end
    drain();

    // Routing by owner, including response error
    bus.instr_req = 1; bus.instr_addr = 32'h600;
    settle(); chk("t5_igrant", bus.instr_gnt, 1'b1); tick();
    bus.instr_req = 0; bus.data_req = 1; bus.data_wr = 1;
    settle(); chk("t5_dgrant", bus.data_gnt, 1'b1); tick();
    bus.data_req = 0; bus.data_wr = 0;
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hA; bus.mem_err = 0;
    settle();
    chk("t5_ivalid", bus.instr_valid, 1'b1);
    chk("t5_irdata", bus.instr_rdata, 32'hA);
    chk("t5_ierr", bus.instr_err, 1'b0);
    tick();
    bus.mem_rdata = 32'hB; bus.mem_err = 1;
    settle();
    chk("t5_dvalid", bus.data_valid, 1'b1);
    chk("t5_drdata", bus.data_rdata, 32'hB);
    chk("t5_derr", bus.data_err, 1'b1);
    chk("t5_ivalid0", bus.instr_valid, 1'b0);
    tick();
    bus.mem_rvalid = 0; bus.mem_err = 0;

    // Orphan response, then reset mid-traffic
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h77;
    settle();
    chk("t6_no_ivalid", bus.instr_valid, 1'b0);
    chk("t6_no_dvalid", bus.data_valid, 1'b0);
    tick();
    bus.mem_rvalid = 0;
    settle(); chk("t6_proto", bus.proto_err, 1'b1); tick();
    bus.instr_req = 1; bus.instr_addr = 32'h700;
    settle(); chk("t6_proto_held", bus.proto_err, 1'b1); tick();
    bus.instr_addr = 32'h704; rst = 1;
    settle();
    chk("t6_rst_req", bus.mem_req, 1'b0);
    chk("t6_rst_proto", bus.proto_err, 1'b0);
    tick();
    rst = 0;
    settle(); chk("t6_post_g0", bus.instr_gnt, 1'b1); tick();
    bus.instr_addr = 32'h708;
    settle(); chk("t6_post_g1", bus.instr_gnt, 1'b1); tick();
    bus.instr_addr = 32'h70c;
    settle(); chk("t6_post_full", bus.mem_req, 1'b0); tick();
    drain();

    // Randomized traffic with legal requesters and an in-order memory
    for (int c = 0; c < 2000; c++) begin
      if (!bus.instr_req || e_igt) begin
        bus.instr_req = 1'($urandom_range(0, 1)); bus.instr_addr = $urandom;
      end
      if (!bus.data_req || e_dgt) begin
        bus.data_req = 1'($urandom_range(0, 1)); bus.data_wr = 1'($urandom_range(0, 1));
        bus.data_addr = $urandom; bus.data_wdata = $urandom;
        bus.data_byteen = 4'($urandom_range(0, 15));
      end
      bus.mem_gnt    = ($urandom_range(0, 3) != 0);
      bus.mem_rvalid = (m_own.size() > 0) && ($urandom_range(0, 1) == 1);
      bus.mem_rdata  = $urandom;
      bus.mem_err    = ($urandom_range(0, 7) == 0);
      settle(); tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
